// File: rtl/team_06_adc_to_i2s_rx.sv
// rtl/team_06_adc_to_i2s_rx.sv - I2S receiver: generates sclk/ws, captures stereo frames from an ADC
module team_06_adc_to_i2s_rx #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serial_in,
  output logic             sclk,
  output logic             ws,
  output logic [WIDTH-1:0] left_out,
  output logic [WIDTH-1:0] right_out,
  output logic             sample_valid,
  input  logic             sample_ack,
  output logic             overrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] left_hold;
  logic             primed;

  logic             tick;
  logic             rise_evt;
  logic             fall_evt;
  logic             slot_start;
  logic             frame_done;
  logic [WIDTH-1:0] shift_next;

  // Event decode: a tick toggles sclk, its direction decides rise or fall.
  always_comb begin
    tick       = en && (div_cnt == DIV_LAST);
    rise_evt   = tick && !sclk;
    fall_evt   = tick && sclk;
    shift_next = {shift_reg[WIDTH-2:0], serial_in};
    // Bit index 0 of a slot carries the LSB of the previous slot (I2S one-bit delay).
    slot_start = rise_evt && (bit_cnt == '0) && primed;
    frame_done = slot_start && !ws;
  end

  // Clock divider producing sclk; disabled engine parks sclk low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Slot counter on sclk falls: toggles ws each WIDTH bits, primes after the first left slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      ws      <= 1'b0;
      primed  <= 1'b0;
    end else if (!en) begin
      bit_cnt <= '0;
      ws      <= 1'b0;
      primed  <= 1'b0;
    end else if (fall_evt) begin
      if (bit_cnt == BIT_LAST) begin
        bit_cnt <= '0;
        ws      <= ~ws;
        if (!ws) begin
          primed <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // Serial shift on sclk rises; the completed left word is parked until the right word lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      left_hold <= '0;
    end else if (!en) begin
      shift_reg <= '0;
    end else if (rise_evt) begin
      shift_reg <= shift_next;
      if (slot_start && ws) begin
        left_hold <= shift_next;
      end
    end
  end

  // Frame presentation, valid/ack handshake and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (frame_done) begin
        left_out     <= left_hold;
        right_out    <= shift_next;
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ack) begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ack) begin
        sample_valid <= 1'b0;
      end
      if (!en) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
